// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit queue.
// Holds the transmit FSM state type, ASCII framing constants and the default FIFO depth.
package uart_tx_pkg;

  localparam int DEPTH_DEFAULT = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Circular byte FIFO with wrap-around pointers and an explicit occupancy count.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
import uart_tx_pkg::*;

module tx_fifo #(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   hz100,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wr_data,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign dropped = push && !do_push;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge hz100) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmit port with a one-cycle txclk strobe per byte.
// Define UART_TX_CRLF_EN to emit a CR ahead of every dequeued LF.
import uart_tx_pkg::*;

module uart_tx_queue #(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   hz100,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             txdata,
  output logic                   txclk,
  input  logic                   txready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  tx_state_t  state;
  logic [7:0] head;
  logic       pop;
  logic       load;
  logic       insert_cr;
  logic       dropped;

  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .hz100   (hz100),
    .reset   (reset),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (count),
    .dropped (dropped)
  );

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign txclk = (state == STROBE);

`ifdef UART_TX_CRLF_EN
  // Set once the CR for the LF at the head has gone out; the LF is popped on the next strobe.
  logic cr_sent;

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset)     cr_sent <= 1'b0;
    else if (load) cr_sent <= insert_cr;
  end

  always_comb begin
    load      = 1'b0;
    pop       = 1'b0;
    insert_cr = 1'b0;
    if (state == IDLE && !empty && txready) begin
      load = 1'b1;
      if (head == ASCII_LF && !cr_sent) insert_cr = 1'b1;
      else                              pop       = 1'b1;
    end
  end
`else
  always_comb begin
    load      = 1'b0;
    pop       = 1'b0;
    insert_cr = 1'b0;
    if (state == IDLE && !empty && txready) begin
      load = 1'b1;
      pop  = 1'b1;
    end
  end
`endif

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      txdata   <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (dropped) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (load) begin
            state  <= STROBE;
            txdata <= insert_cr ? ASCII_CR : head;
          end
        end
        STROBE:  state <= WAIT;
        WAIT:    if (txready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have port: hz100  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: wr_en  input  1  user strobe; enqueue wr_data this cycle.
REQ-005 SHALL have port: wr_data  input  8  byte to transmit.
REQ-006 SHALL have port: full  output  1  high when count == DEPTH.
REQ-007 SHALL have port: empty  output  1  high when count == 0.
REQ-008 SHALL have port: count  output  $clog2(DEPTH)+1  bytes currently queued.
REQ-009 SHALL have port: overflow  output  1  sticky flag; a write was dropped.
REQ-010 SHALL have port: txdata  output  8  byte presented to the UART transmit port.
REQ-011 SHALL have port: txclk  output  1  one-cycle strobe; txdata valid while high.
REQ-012 SHALL have port: txready  input  1  UART transmit port can accept a byte.

Function
REQ-013 SHALL store bytes in a circular FIFO: write and read pointers wrap modulo DEPTH, plus a count register.
REQ-014 SHALL accept a write when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-015 SHALL drop a write that is not accepted and set overflow; overflow stays set until reset.
REQ-016 SHALL make count change by +1 on a write only, -1 on a pop only, and 0 on a simultaneous write and pop.
REQ-017 SHALL implement FSM states IDLE, STROBE and WAIT.
REQ-018 SHALL move IDLE->STROBE when empty==0 and txready==1; on that edge, pop the head byte into the txdata register.
REQ-019 SHALL drive txclk=1 only in STROBE, for exactly one cycle, and then always move STROBE->WAIT.
REQ-020 SHALL move WAIT->IDLE when txready==1, and stay in WAIT while txready==0.
REQ-021 SHALL hold txdata stable from the pop until the next pop.
REQ-022 SHALL give a latency of 2 cycles from a wr_en on an empty queue (edge N) to txclk high (cycle after edge N+1), when txready is held at 1.
REQ-023 SHALL give a throughput of one byte per 3 cycles maximum when txready is held at 1.
REQ-024 SHALL handle wr_en during a pop from a one-entry queue correctly: empty stays 0 and count stays 1.
REQ-025 SHALL generate full, empty and count combinationally from the registered count.

Reset
REQ-026 SHALL, while reset is asserted, immediately force: state=IDLE, pointers=0, count=0, txdata=8'h00, txclk=0, overflow=0.
REQ-027 SHALL discard queued bytes and any in-progress strobe when reset is asserted mid-operation; no txclk after release until a new write.

Configuration
REQ-028 SHALL, with UART_TX_CRLF_EN defined, transmit 8'h0D immediately before every dequeued 8'h0A: two full STROBE/WAIT sequences, with the LF popped only on its own strobe.
REQ-029 SHALL, with UART_TX_CRLF_EN undefined, transmit bytes unmodified.
REQ-030 SHALL, with UART_TX_CRLF_EN defined, leave count unaffected by the inserted CR.

Structure
REQ-031 SHALL put the FSM state enum, ASCII_CR/ASCII_LF constants and DEPTH default in package uart_tx_pkg.
REQ-032 SHALL implement FIFO storage and pointers in sub-module tx_fifo (DEPTH, push/pop/data/count); the FSM stays in uart_tx_queue.

Verification
REQ-033 SHALL cover: write 8'h41 with txready=1 -> txclk high exactly 2 cycles later with txdata=8'h41; empty=1 afterwards.
REQ-034 SHALL cover: write 9 bytes 8'h30..8'h38 back-to-back with txready=0 -> count=8, full=1, overflow=1; after txready=1, 8'h30..8'h37 emerge in order.
REQ-035 SHALL cover: hold txready=0 for 5 cycles after a strobe -> no second txclk until txready returns high, then the next byte.
REQ-036 SHALL cover: count=8 with simultaneous wr_en and pop -> write accepted, count stays 8, overflow stays 0.
REQ-037 SHALL cover: assert reset during STROBE -> txclk=0 the same cycle; count=0; no strobes after release.
REQ-038 SHALL cover: with UART_TX_CRLF_EN, write 8'h0A -> strobes carry 8'h0D then 8'h0A; without it, a single strobe carrying 8'h0A.
